sine_rom_sequencer: RTL and testbench
=====================================

// Module: sine_rom_sequencer
// PURPOSE
//  Burst sine-sample generator. Drives the address of an external async-read sine ROM
//  from a phase accumulator and rebuilds signed samples from the ROM output.
//  Emits samples on a valid/ready stream. Sits between the waveform ROM and the
//  DAC/sink logic; software-style control is a start/abort pulse plus tuning word.
// PARAMETERS
//  DATAW   8   ROM word width (unsigned magnitude in quarter-wave mode)
//  ADDRW   8   ROM address width (ROM depth = 2**ADDRW)
//  PHASEW  24  phase accumulator width; must be >= ADDRW+2
// PORTS
//  clk        in   1         single clock, all logic rising-edge
//  rst        in   1         synchronous, active-high reset
//  start      in   1         pulse: begin burst (ignored while busy)
//  abort      in   1         pulse: terminate burst
//  ftw        in   PHASEW    frequency tuning word, latched on accepted start
//  phase_ofs  in   PHASEW    start phase, latched on accepted start
//  count      in   16        number of samples in burst, latched on accepted start
//  rom_addr   out  ADDRW     to ROM address (combinational from phase register)
//  rom_data   in   DATAW     from ROM, valid in same cycle as rom_addr
//  out_data   out  DATAW+1   signed sample
//  out_valid  out  1         sample valid
//  out_ready  in   1         sink accepts when out_valid && out_ready
//  busy       out  1         high in RUN
//  done       out  1         one-cycle pulse at burst end (normal or abort)
// BEHAVIOUR
//  - Reset: state IDLE, phase=0, remaining=0, out_data=0, out_valid=0, busy=0, done=0.
//  - FSM IDLE->RUN on start; RUN->IDLE on last accept, abort, or count==0 at start.
//  - IDLE & start & count!=0: phase<=phase_ofs, ftw_q<=ftw, remaining<=count, RUN.
//  - IDLE & start & count==0: stay IDLE, done pulse next cycle, no samples.
//  - RUN: slot free = !out_valid | out_ready. If free & remaining!=0: out_data<=sample(phase),
//    out_valid<=1, phase<=phase+ftw_q (mod 2**PHASEW), remaining<=remaining-1.
//    If free & remaining==0: out_valid<=0, done<=1, RUN->IDLE.
//  - Latency: start at cycle 0 -> out_valid=1 at cycle 2; back-to-back 1 sample/cycle
//    when out_ready held high.
//  - Stall: out_valid && !out_ready holds out_data, phase, remaining unchanged.
//  - abort (any state, priority over start): out_valid<=0, RUN->IDLE; done pulse only if
//    it was RUN. Pending sample discarded.
//  - start during RUN ignored. rst overrides everything, mid-burst included.
//  - Phase wraps modulo 2**PHASEW silently; ftw=0 repeats the same sample.
// CONFIGURATION
//  SINE_QUARTER_WAVE_EN defined: ROM holds first quadrant, unsigned. q=phase[PHASEW-1:PHASEW-2],
//    idx=phase[PHASEW-3 -: ADDRW]; rom_addr = q[0] ? ~idx : idx; sample = q[1] ?
//    -{1'b0,rom_data} : {1'b0,rom_data}. Mirror via ~idx accepted (no half-LSB offset).
//  Undefined: ROM holds full period, two's complement. rom_addr=phase[PHASEW-1 -: ADDRW];
//    sample = sign-extended rom_data. Interface identical in both builds.
// TESTING (ROM model rom_data=rom_addr, DATAW=8, ADDRW=8, PHASEW=10, out_ready=1 unless noted)
//  1. QW_EN, phase_ofs=0, ftw=64, count=16 -> 0,64,128,192,255,191,127,63,0,-64,-128,-192,
//     -255,-191,-127,-63; done one cycle after last accept; first valid 2 cycles after start.
//  2. No QW_EN, same stimulus -> sign-extended 0,16,32,...,240 (addr=phase[9:2]).
//  3. Toggle out_ready 1,0,0,1,... during test 1 -> identical sequence, no drop/duplicate,
//     out_data stable while stalled.
//  4. count=0 start -> no out_valid, done pulse next cycle, busy stays 0.
//  5. abort after 3 accepted samples -> out_valid low next cycle, single done pulse,
//     new start then restarts from its phase_ofs.
//  6. rst asserted mid-burst with out_valid=1 -> all outputs at reset values next cycle;
//     start during RUN and phase wrap (ftw=1000) checked for no effect / correct modulo.

Source files
------------

// File: rtl/sine_rom_sequencer.sv
// Burst sine-sample generator: phase accumulator -> async ROM address -> signed sample stream.
// Latency: start accepted at cycle 0 gives the first out_valid at cycle 2, then 1 sample/cycle.
// Backpressure: out_valid && !out_ready freezes out_data, phase and remaining until accepted.
//
// Build option: define SINE_QUARTER_WAVE_EN when the ROM holds only the first quadrant
// (unsigned). Without it, the ROM holds a full two's-complement period.
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   start, abort         control pulses (abort has priority; start ignored while busy)
//   ftw, phase_ofs       tuning word and start phase, latched on an accepted start
//   count                burst length in samples, latched on an accepted start
//   rom_addr / rom_data  async-read ROM interface (data valid in the same cycle)
//   out_data/out_valid/out_ready  signed sample stream
//   busy, done           busy while a burst runs; done pulses once at burst end
module sine_rom_sequencer #(
  parameter int DATAW  = 8,
  parameter int ADDRW  = 8,
  parameter int PHASEW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PHASEW-1:0] ftw,
  input  logic [PHASEW-1:0] phase_ofs,
  input  logic [15:0]       count,
  output logic [ADDRW-1:0]  rom_addr,
  input  logic [DATAW-1:0]  rom_data,
  output logic [DATAW:0]    out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_d;
  logic [PHASEW-1:0]  phase, phase_d;
  logic [PHASEW-1:0]  ftw_q, ftw_d;
  logic [15:0]        remaining, remaining_d;
  logic [DATAW:0]     out_data_d;
  logic               out_valid_d;
  logic               done_d;
  logic [DATAW:0]     sample;
  logic               slot_free;

`ifdef SINE_QUARTER_WAVE_EN
  logic [1:0]         quad;
  logic [ADDRW-1:0]   idx;

  // Top two phase bits pick the quadrant; odd quadrants read the table backwards,
  // the second half-period negates the magnitude.
  assign quad     = phase[PHASEW-1 -: 2];
  assign idx      = phase[PHASEW-3 -: ADDRW];
  assign rom_addr = quad[0] ? ~idx : idx;
  assign sample   = quad[1] ? -{1'b0, rom_data} : {1'b0, rom_data};
`else
  assign rom_addr = phase[PHASEW-1 -: ADDRW];
  assign sample   = {rom_data[DATAW-1], rom_data};
`endif

  assign busy      = (state == RUN);
  // The output register can take a new sample when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_d     = state;
    phase_d     = phase;
    ftw_d       = ftw_q;
    remaining_d = remaining;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    done_d      = 1'b0;

    if (abort) begin
      // Any pending sample is dropped; only a running burst reports completion.
      out_valid_d = 1'b0;
      state_d     = IDLE;
      done_d      = (state == RUN);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != 16'd0) begin
              phase_d     = phase_ofs;
              ftw_d       = ftw;
              remaining_d = count;
              state_d     = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (slot_free) begin
            if (remaining != 16'd0) begin
              out_data_d  = sample;
              out_valid_d = 1'b1;
              phase_d     = phase + ftw_q;
              remaining_d = remaining - 16'd1;
            end else begin
              // Last sample has just been accepted (or was never stalled).
              out_valid_d = 1'b0;
              done_d      = 1'b1;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      ftw_q     <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      ftw_q     <= ftw_d;
      remaining <= remaining_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Bench for sine_rom_sequencer with a ROM that returns its own address.
// Expected samples come from a closed-form phase model: phase_k = ofs + k*ftw mod 2**PHASEW.
// Random bursts, ready patterns, aborts and a mid-burst reset are exercised.
module tb_sine_rom_sequencer;
  localparam int DATAW  = 8;
  localparam int ADDRW  = 8;
  localparam int PHASEW = 10;
  localparam int PMOD   = 1 << PHASEW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [PHASEW-1:0] ftw;
  logic [PHASEW-1:0] phase_ofs;
  logic [15:0]       count;
  logic [ADDRW-1:0]  rom_addr;
  logic [DATAW-1:0]  rom_data;
  logic [DATAW:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr;

  sine_rom_sequencer #(.DATAW(DATAW), .ADDRW(ADDRW), .PHASEW(PHASEW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ftw(ftw),
    .phase_ofs(phase_ofs), .count(count), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waveform value at a given phase, from the ROM contents (value == address).
  function automatic int exp_sample(input int ph);
    int p, quad, pos, mag, a;
    p = ph % PMOD;
`ifdef SINE_QUARTER_WAVE_EN
    quad = p / (PMOD / 4);
    pos  = p % (PMOD / 4);
    mag  = (quad % 2 == 1) ? (PMOD / 4 - 1 - pos) : pos;
    a    = 0;
    return (quad >= 2) ? -mag : mag;
`else
    quad = 0; pos = 0; mag = 0;
    a = p / (PMOD / 256);
    return (a >= 128) ? a - 256 : a;
`endif
  endfunction

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,...
  // abort_at >= 1: abort once that many samples have been accepted.
  task automatic run_burst(input int ofs, input int f, input int cnt, input int rmode,
                           input int abort_at, input bit mid_start);
    int acc, ndone, done_cyc, last_cyc, stop_cyc, pd, exp_acc, exp_done;
    bit fin, pv, pr;
    acc = 0; ndone = 0; done_cyc = -1; last_cyc = -1; stop_cyc = -1;
    pd = 0; fin = 0; pv = 0; pr = 0;
    phase_ofs = ofs[PHASEW-1:0];
    ftw       = f[PHASEW-1:0];
    count     = cnt[15:0];
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 0) begin
        check("busy_after_start", int'(busy), int'(cnt != 0));
        check("valid_cycle1", int'(out_valid), 0);
      end
      if (cyc == 1 && cnt != 0) check("first_valid_latency", int'(out_valid), 1);
      if (pv && !pr) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_data_held", sdata(), pd);
      end
      if (stop_cyc >= 0 && cyc == stop_cyc + 1) check("abort_valid_low", int'(out_valid), 0);

      abort = 1'b0;
      start = 1'b0;
      if (abort_at > 0 && acc == abort_at && stop_cyc < 0) begin
        abort    = 1'b1;
        stop_cyc = cyc;
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 3 == 0);
      endcase
      if (mid_start && cyc == 3) begin
        start     = 1'b1;
        ftw       = PHASEW'($urandom);
        phase_ofs = PHASEW'($urandom);
        count     = 16'($urandom_range(1, 5));
      end
      if (!abort && out_valid && out_ready) begin
        if (acc < cnt) check($sformatf("sample%0d", acc), sdata(), exp_sample(ofs + acc * f));
        else check("extra_sample", acc, cnt);
        acc++;
        if (acc == cnt) last_cyc = cyc;
      end
      pv = out_valid && !abort;
      pr = out_ready;
      pd = sdata();
      if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; out_ready = 1'b1;

    exp_acc  = (abort_at > 0) ? abort_at : cnt;
    exp_done = (cnt == 0) ? 0 : (abort_at > 0) ? stop_cyc + 1 : last_cyc + 1;
    check("burst_timeout", int'(fin), 1);
    check("done_pulses", ndone, 1);
    check("accept_count", acc, exp_acc);
    check("done_timing", done_cyc, exp_done);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ftw = '0; phase_ofs = '0; count = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", sdata(), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rom_addr), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(0, 64, 16, 0, 0, 1'b0);       // reference sweep
    run_burst(0, 64, 16, 2, 0, 1'b0);       // stalls 1,0,0 pattern
    run_burst(37, 0, 5, 1, 0, 1'b0);        // ftw=0 repeats one sample
    run_burst(900, 1000, 20, 0, 0, 1'b0);   // phase wrap
    run_burst(123, 77, 0, 0, 0, 1'b0);      // count=0: done only
    run_burst(200, 50, 10, 0, 3, 1'b0);     // abort after 3 samples
    run_burst(512, 96, 8, 1, 0, 1'b0);      // restart after abort from own phase
    run_burst(10, 33, 12, 0, 0, 1'b1);      // start during RUN ignored
    for (int i = 0; i < 6; i++)
      run_burst(int'($urandom_range(0, PMOD - 1)), int'($urandom_range(0, PMOD - 1)),
                int'($urandom_range(1, 24)), int'($urandom_range(0, 2)),
                (i == 3) ? int'($urandom_range(1, 2)) : 0, 1'b0);

    // abort in IDLE, alone and together with start: no burst, no done
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_done", int'(done), 0);
    check("idle_abort_busy", int'(busy), 0);
    abort = 1'b1; start = 1'b1; count = 16'd5;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_valid", int'(out_valid), 0);

    // synchronous reset mid-burst
    phase_ofs = 10'd100; ftw = 10'd37; count = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", sdata(), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_addr", int'(rom_addr), 0);
    @(posedge clk); #1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);
    run_burst(300, 129, 9, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
